// File: rtl/nn_fixed_pkg.sv
// Shared sign-magnitude fixed-point definitions for the accelerator datapath.
// Holds default formats, field indices and the round/saturate helper.
package nn_fixed_pkg;

    localparam int SM_WIDTH    = 8;
    localparam int SM_FRAC     = 3;
    localparam int SM_SIGN_BIT = SM_WIDTH - 1;
    localparam int SM_MAG_MSB  = SM_WIDTH - 2;

    // Widest value format the helper supports; accumulators up to 2x that.
    localparam int SM_MAXW     = 32;
    localparam int SM_ACC_MAXW = 2 * SM_MAXW;

    typedef logic [SM_ACC_MAXW-1:0] sm_acc_t;
    typedef logic [SM_MAXW:0]       sm_res_t;

    // Round half up on the magnitude, then clamp to the largest magnitude.
    // Result is {ovf, mag}; mag is zero-extended to SM_MAXW bits.
    function automatic sm_res_t sm_round_sat(
        input sm_acc_t acc,
        input int      width = SM_WIDTH,
        input int      frac  = SM_FRAC
    );
        sm_acc_t m;
        sm_acc_t lim;
        sm_acc_t rb;
        rb  = '0;
        rb[0] = acc[frac-1];
        m   = (acc >> frac) + rb;
        lim = (SM_ACC_MAXW'(1) << (width - 1)) - SM_ACC_MAXW'(1);
        if (m > lim) begin
            return {1'b1, lim[SM_MAXW-1:0]};
        end
        return {1'b0, m[SM_MAXW-1:0]};
    endfunction

endpackage

// File: rtl/serial_mult_lane.sv
// One neuron lane: shift-add accumulation of a serial weight, then
// round, saturate and sign resolution into a held result register.
module serial_mult_lane
    import nn_fixed_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH,
    parameter int FRAC  = SM_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fin,
    input  logic             w_bit,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] out_val,
    output logic             out_ovf
);

    localparam int ACCW = 2 * (WIDTH - 1);
    localparam int PADW = ACCW - (WIDTH - 1);

    logic [ACCW-1:0]  acc_q, acc_d;
    logic [WIDTH-2:0] a_mag_q, a_mag_d;
    logic             a_sign_q, a_sign_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;

    sm_res_t          rs;
    logic [WIDTH-2:0] fin_mag;
    logic             fin_sign;
    logic             unused_rs;

    assign rs        = sm_round_sat(SM_ACC_MAXW'(acc_q), WIDTH, FRAC);
    assign fin_mag   = rs[WIDTH-2:0];
    assign fin_sign  = (a_sign_q ^ w_bit) & (|fin_mag);
    assign unused_rs = ^rs[SM_MAXW-1:WIDTH-1];

    // Next-state for operand latch, accumulator and result registers.
    always_comb begin
        acc_d    = acc_q;
        a_mag_d  = a_mag_q;
        a_sign_d = a_sign_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        if (load) begin
            a_mag_d  = in_val[WIDTH-2:0];
            a_sign_d = in_val[WIDTH-1];
            acc_d    = w_bit ? {{PADW{1'b0}}, in_val[WIDTH-2:0]} : '0;
        end else if (step) begin
            acc_d = (acc_q << 1)
                  + (w_bit ? {{PADW{1'b0}}, a_mag_q} : '0);
        end else if (fin) begin
            res_d = {fin_sign, fin_mag};
            ovf_d = rs[SM_MAXW];
        end
    end

    // Lane state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            a_mag_q  <= '0;
            a_sign_q <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            a_mag_q  <= a_mag_d;
            a_sign_q <= a_sign_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_val = res_q;
    assign out_ovf = ovf_q;

endmodule

// File: rtl/bit_serial_mult_array.sv
// Bit-serial multiplier: one serial weight times LANES neuron values.
// Owns the IDLE/RUN sequencer, bit counter and start/busy/valid handshake.
module bit_serial_mult_array
    import nn_fixed_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH,
    parameter int FRAC  = SM_FRAC,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LANES*WIDTH-1:0] in_neuron,
    input  logic                   w_bit,
    output logic                   busy,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          load, step, fin;

    // Sequencer: T0 loads, middle edges shift, the last edge finalises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = CW'(1);
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    fin     = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    step  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign out_valid = valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serial_mult_lane #(
            .WIDTH(WIDTH),
            .FRAC (FRAC)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .step   (step),
            .fin    (fin),
            .w_bit  (w_bit),
            .in_val (in_neuron[i*WIDTH +: WIDTH]),
            .out_val(out_data[i*WIDTH +: WIDTH]),
            .out_ovf(out_ovf[i])
        );
    end

endmodule

// File: tb/tb_bit_serial_mult_array.sv
// Directed bench for bit_serial_mult_array at WIDTH=8, FRAC=3, LANES=4.
// Expected products are hand-computed sign-magnitude constants.
module tb_bit_serial_mult_array;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in_neuron;
    logic        w_bit;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_ovf;

    int checks;
    int errors;

    bit_serial_mult_array #(
        .WIDTH(8),
        .FRAC (3),
        .LANES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_neuron(in_neuron),
        .w_bit    (w_bit),
        .busy     (busy),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full operation; inputs scrambled after T0, start optionally held.
    task automatic run_op(
        input logic [31:0] nrn,
        input logic [6:0]  wm,
        input logic        ws,
        input logic        hold,
        input logic [31:0] exp_d,
        input logic [3:0]  exp_o,
        input string       nm
    );
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start     = (k == 0) ? 1'b1 : hold;
            in_neuron = (k == 0) ? nrn : ~nrn;
            w_bit     = (k < 7) ? wm[6-k] : ws;
            @(posedge clk);
            #1;
            checks++;
            if (k < 7) begin
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s t%0d busy=%b valid=%b want 1 0",
                             nm, k, busy, out_valid);
                end
            end else begin
                if (busy !== 1'b0 || out_valid !== 1'b1 ||
                    out_data !== exp_d || out_ovf !== exp_o) begin
                    errors++;
                    $display("FAIL %s res busy=%b v=%b d=%h o=%b want 0 1 %h %b",
                             nm, busy, out_valid, out_data, out_ovf,
                             exp_d, exp_o);
                end
            end
        end
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== 32'h0 || out_ovf !== 4'h0) begin
            errors++;
            $display("FAIL reset busy=%b v=%b d=%h o=%b want 0 0 0 0",
                     busy, out_valid, out_data, out_ovf);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_op({8'h00, 8'h81, 8'h01, 8'h14}, 7'h18, 1'b1, 1'b0,
               {8'h00, 8'h03, 8'h83, 8'hBC}, 4'b0000, "basic");
    endtask

    task automatic test_rounding();
        run_op({8'h7F, 8'h81, 8'h01, 8'h14}, 7'h04, 1'b1, 1'b0,
               {8'hC0, 8'h01, 8'h81, 8'h8A}, 4'b0000, "round");
        run_op({8'h85, 8'h81, 8'h01, 8'h14}, 7'h01, 1'b0, 1'b0,
               {8'h81, 8'h00, 8'h00, 8'h03}, 4'b0000, "negzero");
    endtask

    task automatic test_saturation();
        run_op({8'h7F, 8'h88, 8'h00, 8'h01}, 7'h7F, 1'b0, 1'b0,
               {8'h7F, 8'hFF, 8'h00, 8'h10}, 4'b1000, "sat");
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_neuron = 32'hA5A5_A5A5;
            w_bit     = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 ||
                out_data !== {8'h7F, 8'hFF, 8'h00, 8'h10} ||
                out_ovf !== 4'b1000) begin
                errors++;
                $display("FAIL hold c%0d v=%b b=%b d=%h o=%b want 0 0 7fff0010 1000",
                         k, out_valid, busy, out_data, out_ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op({8'h00, 8'h81, 8'h01, 8'h14}, 7'h18, 1'b1, 1'b1,
               {8'h00, 8'h03, 8'h83, 8'hBC}, 4'b0000, "b2b0");
        run_op({8'h7F, 8'h88, 8'h00, 8'h01}, 7'h7F, 1'b0, 1'b1,
               {8'h7F, 8'hFF, 8'h00, 8'h10}, 4'b1000, "b2b1");
        run_op({8'h85, 8'h81, 8'h01, 8'h14}, 7'h01, 1'b0, 1'b0,
               {8'h81, 8'h00, 8'h00, 8'h03}, 4'b0000, "b2b2");
    endtask

    task automatic test_reset_mid_op();
        logic [6:0] wm;
        wm = 7'h18;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start     = (k == 0);
            in_neuron = 32'h7F7F_7F7F;
            w_bit     = wm[6-k];
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== 32'h0 || out_ovf !== 4'h0) begin
            errors++;
            $display("FAIL midreset busy=%b v=%b d=%h o=%b want 0 0 0 0",
                     busy, out_valid, out_data, out_ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort c%0d v=%b b=%b want 0 0",
                         k, out_valid, busy);
            end
        end
        run_op({8'h00, 8'h81, 8'h01, 8'h14}, 7'h18, 1'b1, 1'b0,
               {8'h00, 8'h03, 8'h83, 8'hBC}, 4'b0000, "recover");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        in_neuron = '0;
        w_bit     = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_hold();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_mult_array.md
# bit_serial_mult_array

Parametrised bit-serial fixed-point multiplier. One serially streamed weight multiplies `LANES` parallel sign-magnitude neuron values. Each operation takes `WIDTH` cycles. It sits between the neuron register bank and the accumulator stage of the accelerator. Compared with the previous single-lane multiplier, it adds:
- width, fraction and lane-count parameters
- a start/busy/valid handshake
- a correct round-half-up
- saturation with an overflow flag
- negative-zero suppression

## Interface
- `WIDTH`, default 8: total bits per value, sign-magnitude. Bit `WIDTH-1` is the sign; bits `WIDTH-2:0` are the magnitude.
- `FRAC`, default 3: fraction bits in the magnitude; 1 ≤ `FRAC` ≤ `WIDTH-2`.
- `LANES`, default 4: number of parallel neuron lanes sharing one weight stream.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; accepted only when `busy`=0.
- `in_neuron` in `LANES*WIDTH`: lane *i* at bits `[i*WIDTH +: WIDTH]`; captured on the accepting edge.
- `w_bit` in 1: serial weight. Sent as magnitude MSB first, then the sign bit last.
- `busy` out 1: operation in progress.
- `out_valid` out 1: one-cycle pulse; a new result is on `out_data`.
- `out_data` out `LANES*WIDTH`: sign-magnitude products, same packing as `in_neuron`. Held until the next result.
- `out_ovf` out `LANES`: per-lane saturation flag. Updated together with `out_data`.

## Operation
- Reset (synchronous, active-high) sets `busy`, `out_valid`, `out_data` and `out_ovf` to 0. It also clears the bit counter and all partial products.
- Reset asserted mid-operation aborts the operation. No `out_valid` is produced.
- States: IDLE and RUN.
- IDLE → RUN when `start`=1 at edge T0. At T0:
  - `in_neuron` is latched.
  - `w_bit` is sampled as weight magnitude bit `WIDTH-2`.
- Magnitude bits are sampled at edges T0 … T(`WIDTH-2`), MSB first.
- At each magnitude edge, per lane: `acc` ← (`acc` << 1) + (`a_mag` if `w_bit` else 0). `acc` starts at 0 at T0.
- The sign bit is sampled at edge T(`WIDTH-1`). At that edge the result is registered and the FSM returns to IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- Per-lane result arithmetic:
  - `acc` is `2*(WIDTH-1)` bits wide, with `2*FRAC` fraction bits.
  - `m` = (`acc` >> `FRAC`) + `acc[FRAC-1]` (round half up on magnitude).
  - If `m` > 2^(`WIDTH-1`)−1: magnitude = 2^(`WIDTH-1`)−1 and `ovf`=1. Otherwise magnitude = `m` and `ovf`=0.
  - Sign = `a_sign` XOR `w_sign`, forced to 0 when the final magnitude is 0 (no negative zero).
- Lanes are fully independent. A zero or saturated result in one lane does not affect the others.

## Timing
- `busy` is 1 after edges T0 … T(`WIDTH-2`), and 0 after edge T(`WIDTH-1`).
- `out_valid` is 1 for exactly the cycle after edge T(`WIDTH-1`). `out_data` and `out_ovf` become valid in that same cycle.
- Latency: result visible `WIDTH-1` cycles after the start edge.
- Throughput: a new `start` may be accepted at edge T(`WIDTH`), i.e. while `out_valid`=1. This gives one operation per `WIDTH` cycles.
- `in_neuron` may change freely after T0.
- `w_bit` is only meaningful at edges T0 … T(`WIDTH-1`).

## Structure
- Shared package `nn_fixed_pkg` holds:
  - `WIDTH`/`FRAC` defaults
  - sign-magnitude field-index constants
  - a pure function `sm_round_sat(acc) → {ovf, mag}`, reused by the accumulator stage
- One sub-module, `serial_mult_lane`: per-lane shift-add accumulator plus round/saturate/sign logic, generated `LANES` times.
- The top level owns the FSM, the bit counter (`$clog2(WIDTH)` bits) and the handshake.

## Test plan
All cases use `WIDTH`=8, `FRAC`=3.
- Basic product: lane0 = 0x14 (2.5), weight mag 0x18 then sign 1 (−3.0) → `out_valid` pulses after 7 cycles; lane0 = 0xBC (−7.5), `ovf`=0.
- Rounding and negative zero:
  - lane1 = 0x01, weight mag 0x04, sign 1 → 0x81.
  - lane2 = 0x81, weight mag 0x01, sign 0 → 0x00 (not 0x80).
- Saturation: lane3 = 0x7F, weight mag 0x7F, sign 0 → 0x7F, `out_ovf[3]`=1; lanes 0–2 unaffected.
- Back-to-back: `start` held high continuously → `out_valid` every 8 cycles. `start` pulses during `busy` → ignored, results unchanged.
- Reset at T3 of an operation → all outputs 0 next cycle, no `out_valid`. The following `start` produces a correct result.
